neo_lb_pingpong: RTL and testbench

- Parametrised, double-buffered sprite line buffer.
- Successor to the fixed 4-bank line buffer arrangement in the video mixer: two banks swap roles each line. One bank takes sprite pixels from the renderer. The other is streamed out to the palette-address mixer.
- Adds what the fixed version lacks:
  - generic pixel, palette and line widths;
  - decrementing write direction for horizontal flip;
  - explicit out-of-range write clipping;
  - registered read pipeline with an opaque flag.

---
 rtl/neo_lb_pkg.sv | 17 +
 rtl/neo_lb_ram.sv | 31 +++
 rtl/neo_lb_pingpong.sv | 173 +++++++++++++++++
 tb/tb_neo_lb_pingpong.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/neo_lb_pkg.sv
// Shared defaults and helpers for the ping-pong sprite line buffer.
// Optional clear-after-read is selected by NEO_LB_CLEAR_EN in the top level.
package neo_lb_pkg;

   localparam int COL_W_DEF    = 4;
   localparam int PAL_W_DEF    = 8;
   localparam int LINE_LEN_DEF = 320;
   localparam int ADDR_W_DEF   = 9;

   // Colour index that marks a pixel as see-through.
   localparam int COL_TRANSPARENT = 0;

   function automatic int pix_w(input int pal_w, input int col_w);
      return pal_w + col_w;
   endfunction

endpackage

// File: rtl/neo_lb_ram.sv
// One line bank: simple dual-port RAM with a synchronous, registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module neo_lb_ram #(
   parameter int DEPTH  = 320,
   parameter int DATA_W = 12,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata_reg <= mem[raddr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/neo_lb_pingpong.sv
// Double-buffered sprite line buffer: one bank is rendered while the other is displayed.
// Define NEO_LB_CLEAR_EN to zero each pixel one cycle after it is read out.
module neo_lb_pingpong
   import neo_lb_pkg::*;
#(
   parameter int COL_W    = COL_W_DEF,
   parameter int PAL_W    = PAL_W_DEF,
   parameter int LINE_LEN = LINE_LEN_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic                              CLK_6MB,
   input  logic                              nRST,
   input  logic                              SWAP,
   input  logic                              LD,
   input  logic [ADDR_W-1:0]                 LD_ADDR,
   input  logic                              FLIP,
   input  logic                              WE,
   input  logic [COL_W-1:0]                  WR_COL,
   input  logic [PAL_W-1:0]                  WR_PAL,
   input  logic                              RD_EN,
   output logic [pix_w(PAL_W, COL_W)-1:0]    PA_OUT,
   output logic                              OPAQUE,
   output logic                              BANK
);

   localparam int               PIX_W    = pix_w(PAL_W, COL_W);
   localparam logic [ADDR_W:0]  LINE_END = (ADDR_W+1)'(LINE_LEN);

   logic              bank_reg;
   logic              flip_reg;
   logic [ADDR_W-1:0] wr_cnt_reg;
   logic [ADDR_W:0]   rd_cnt_reg;
   logic              rd_valid_s1_reg;
   logic              rd_bank_s1_reg;
   logic [PIX_W-1:0]  pa_reg;
   logic              opaque_reg;

   logic [ADDR_W-1:0] wr_addr;
   logic              wr_flip;
   logic              wr_ok;
   logic [ADDR_W-1:0] wr_cnt_next;
   logic [ADDR_W:0]   rd_addr;
   logic              rd_bank;
   logic              rd_ok;
   logic [ADDR_W:0]   rd_cnt_next;
   logic [PIX_W-1:0]  pa_next;
   logic              opaque_next;

   logic              clr_valid;
   logic              clr_bank;
   logic [ADDR_W-1:0] clr_addr;

   logic [1:0]        ram_we;
   logic [1:0]        ram_re;
   logic [ADDR_W-1:0] ram_waddr [2];
   logic [PIX_W-1:0]  ram_wdata [2];
   logic [PIX_W-1:0]  ram_rdata [2];

   // LD takes effect in its own cycle so LD+WE writes straight at LD_ADDR.
   always_comb begin
      wr_addr     = LD ? LD_ADDR : wr_cnt_reg;
      wr_flip     = LD ? FLIP : flip_reg;
      wr_ok       = WE && (WR_COL != COL_W'(COL_TRANSPARENT))
                    && ({1'b0, wr_addr} < LINE_END);
      wr_cnt_next = wr_addr;
      if (WE) begin
         wr_cnt_next = wr_flip ? (wr_addr - ADDR_W'(1)) : (wr_addr + ADDR_W'(1));
      end
   end

   // During SWAP the read side already targets the incoming read bank at address 0.
   always_comb begin
      rd_addr     = SWAP ? '0 : rd_cnt_reg;
      rd_bank     = SWAP ? bank_reg : ~bank_reg;
      rd_ok       = RD_EN && (rd_addr < LINE_END);
      rd_cnt_next = rd_ok ? (rd_addr + (ADDR_W+1)'(1)) : rd_addr;
   end

`ifdef NEO_LB_CLEAR_EN
   logic              clr_valid_reg;
   logic              clr_bank_reg;
   logic [ADDR_W-1:0] clr_addr_reg;

   always_ff @(posedge CLK_6MB or negedge nRST) begin
      if (!nRST) begin
         clr_valid_reg <= 1'b0;
         clr_bank_reg  <= 1'b0;
         clr_addr_reg  <= '0;
      end else begin
         clr_valid_reg <= rd_ok;
         clr_bank_reg  <= rd_bank;
         clr_addr_reg  <= rd_addr[ADDR_W-1:0];
      end
   end

   assign clr_valid = clr_valid_reg;
   assign clr_bank  = clr_bank_reg;
   assign clr_addr  = clr_addr_reg;
`else
   assign clr_valid = 1'b0;
   assign clr_bank  = 1'b0;
   assign clr_addr  = '0;
`endif

   // The clear always targets the bank read a cycle earlier, which is never the
   // current write bank, so giving the renderer precedence costs nothing.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic BANK_ID = 1'(gi);
      logic wr_hit;
      logic clr_hit;

      assign wr_hit        = wr_ok && (bank_reg == BANK_ID);
      assign clr_hit       = clr_valid && (clr_bank == BANK_ID);
      assign ram_we[gi]    = wr_hit || clr_hit;
      assign ram_waddr[gi] = wr_hit ? wr_addr : clr_addr;
      assign ram_wdata[gi] = wr_hit ? {WR_PAL, WR_COL} : '0;
      assign ram_re[gi]    = rd_ok && (rd_bank == BANK_ID);

      neo_lb_ram #(
         .DEPTH  (LINE_LEN),
         .DATA_W (PIX_W),
         .ADDR_W (ADDR_W)
      ) u_ram (
         .clk   (CLK_6MB),
         .we    (ram_we[gi]),
         .waddr (ram_waddr[gi]),
         .wdata (ram_wdata[gi]),
         .re    (ram_re[gi]),
         .raddr (rd_addr[ADDR_W-1:0]),
         .rdata (ram_rdata[gi])
      );
   end

   always_comb begin
      pa_next     = '0;
      opaque_next = 1'b0;
      if (rd_valid_s1_reg) begin
         pa_next     = ram_rdata[rd_bank_s1_reg];
         opaque_next = (pa_next[COL_W-1:0] != COL_W'(COL_TRANSPARENT));
      end
   end

   always_ff @(posedge CLK_6MB or negedge nRST) begin
      if (!nRST) begin
         bank_reg        <= 1'b0;
         flip_reg        <= 1'b0;
         wr_cnt_reg      <= '0;
         rd_cnt_reg      <= '0;
         rd_valid_s1_reg <= 1'b0;
         rd_bank_s1_reg  <= 1'b0;
         pa_reg          <= '0;
         opaque_reg      <= 1'b0;
      end else begin
         if (SWAP) begin
            bank_reg <= ~bank_reg;
         end
         if (LD) begin
            flip_reg <= FLIP;
         end
         wr_cnt_reg      <= wr_cnt_next;
         rd_cnt_reg      <= rd_cnt_next;
         rd_valid_s1_reg <= rd_ok;
         rd_bank_s1_reg  <= rd_bank;
         pa_reg          <= pa_next;
         opaque_reg      <= opaque_next;
      end
   end

   assign PA_OUT = pa_reg;
   assign OPAQUE = opaque_reg;
   assign BANK   = bank_reg;

endmodule

// File: tb/tb_neo_lb_pingpong.sv
// Directed bench for neo_lb_pingpong with default parameters (12-bit pixels, 320-pixel line).
// Expected values are hand-computed; the clear-after-read check follows NEO_LB_CLEAR_EN.
module tb_neo_lb_pingpong;

   logic        CLK_6MB = 1'b0;
   logic        nRST    = 1'b1;
   logic        SWAP    = 1'b0;
   logic        LD      = 1'b0;
   logic [8:0]  LD_ADDR = '0;
   logic        FLIP    = 1'b0;
   logic        WE      = 1'b0;
   logic [3:0]  WR_COL  = '0;
   logic [7:0]  WR_PAL  = '0;
   logic        RD_EN   = 1'b0;
   logic [11:0] PA_OUT;
   logic        OPAQUE;
   logic        BANK;

   int total  = 0;
   int passed = 0;

   neo_lb_pingpong dut (
      .CLK_6MB (CLK_6MB),
      .nRST    (nRST),
      .SWAP    (SWAP),
      .LD      (LD),
      .LD_ADDR (LD_ADDR),
      .FLIP    (FLIP),
      .WE      (WE),
      .WR_COL  (WR_COL),
      .WR_PAL  (WR_PAL),
      .RD_EN   (RD_EN),
      .PA_OUT  (PA_OUT),
      .OPAQUE  (OPAQUE),
      .BANK    (BANK)
   );

   always #5 CLK_6MB = ~CLK_6MB;

   task automatic step();
      @(posedge CLK_6MB);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) begin
         passed++;
         $display("check %s: got %h expected %h ok", tag, act, exp);
      end else begin
         $error("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic load(input logic [8:0] addr, input logic flip);
      LD = 1'b1; LD_ADDR = addr; FLIP = flip;
      step();
      LD = 1'b0; FLIP = 1'b0;
   endtask

   task automatic wr(input logic [3:0] col, input logic [7:0] pal);
      WE = 1'b1; WR_COL = col; WR_PAL = pal;
      step();
      WE = 1'b0; WR_COL = '0; WR_PAL = '0;
   endtask

   task automatic swap();
      SWAP = 1'b1;
      step();
      SWAP = 1'b0;
   endtask

   // One isolated read: its pixel is on PA_OUT two edges after RD_EN.
   task automatic rd_chk(input string tag, input logic [11:0] exp);
      logic [3:0] col;
      col = exp[3:0];
      RD_EN = 1'b1;
      step();
      RD_EN = 1'b0;
      step();
      chk(tag, 32'(PA_OUT), 32'(exp));
      chk({tag, "_opq"}, 32'(OPAQUE), 32'(col != 4'd0));
   endtask

   task automatic skip(input int n);
      RD_EN = 1'b1;
      repeat (n) step();
      RD_EN = 1'b0;
      step();
      step();
   endtask

   initial begin
      logic [11:0] exp_clr;

      // Reset values
      #2 nRST = 1'b0;
      #6;
      chk("rst_pa", 32'(PA_OUT), 32'h0);
      chk("rst_opq", 32'(OPAQUE), 32'h0);
      chk("rst_bank", 32'(BANK), 32'h0);
      #4 nRST = 1'b1;
      step();

      // Preload bank 0 so untouched/transparent addresses have known contents
      load(9'd11, 1'b0);  wr(4'h9, 8'h3A);
      load(9'd2, 1'b0);   wr(4'h6, 8'h44);
      load(9'd317, 1'b0); wr(4'h6, 8'h55);

      // Plain write 10..12; the transparent pixel leaves addr 11 alone
      load(9'd10, 1'b0);
      wr(4'h1, 8'h22); wr(4'h0, 8'h22); wr(4'h5, 8'h22);

      // Flip, with LD and the first WE in the same cycle: 20,19,18
      LD = 1'b1; LD_ADDR = 9'd20; FLIP = 1'b1;
      WE = 1'b1; WR_COL = 4'h3; WR_PAL = 8'h01;
      step();
      LD = 1'b0; FLIP = 1'b0; WE = 1'b0;
      wr(4'h4, 8'h01); wr(4'h5, 8'h01);

      // Left-edge wrap (510,511 clipped) and right-edge clipping (320,321)
      load(9'd510, 1'b0);
      repeat (4) wr(4'h7, 8'h10);
      load(9'd318, 1'b0);
      repeat (4) wr(4'h7, 8'h11);

      // SWAP with coincident WE (old bank 0) and RD_EN (addr 0 of new read bank 0)
      load(9'd100, 1'b0);
      SWAP = 1'b1; WE = 1'b1; WR_COL = 4'hC; WR_PAL = 8'h66; RD_EN = 1'b1;
      step();
      SWAP = 1'b0; WE = 1'b0; WR_COL = '0; WR_PAL = '0; RD_EN = 1'b0;
      chk("swap_bank", 32'(BANK), 32'h1);
      step();
      chk("rd_a0", 32'(PA_OUT), 32'h107);
      chk("rd_a0_opq", 32'(OPAQUE), 32'h1);

      rd_chk("rd_a1", 12'h107);
      rd_chk("rd_a2_untouched", 12'h446);
      skip(7);
      rd_chk("rd_a10", 12'h221);
      rd_chk("rd_a11_transp", 12'h3A9);
      rd_chk("rd_a12", 12'h225);
      skip(5);
      rd_chk("rd_a18_flip", 12'h015);
      rd_chk("rd_a19_flip", 12'h014);
      rd_chk("rd_a20_flip", 12'h013);
      skip(79);
      rd_chk("rd_a100_swapwe", 12'h66C);
      skip(216);
      rd_chk("rd_a317_untouched", 12'h556);
      rd_chk("rd_a318", 12'h117);
      rd_chk("rd_a319", 12'h117);
      rd_chk("rd_a320_end", 12'h000);
      rd_chk("rd_a321_sat", 12'h000);

      // Two swaps with no writes bring bank 0 back to the read side
      swap();
      chk("swap2_bank", 32'(BANK), 32'h0);
      swap();
      chk("swap3_bank", 32'(BANK), 32'h1);
      skip(12);
`ifdef NEO_LB_CLEAR_EN
      exp_clr = 12'h000;
`else
      exp_clr = 12'h225;
`endif
      rd_chk("rd_a12_after_line", exp_clr);

      // Mid-line asynchronous reset while streaming
      swap();
      load(9'd5, 1'b0);
      wr(4'hF, 8'h7E);
      swap();
      skip(5);
      RD_EN = 1'b1;
      step();
      step();
      chk("stream_pa", 32'(PA_OUT), 32'h7EF);
      chk("stream_opq", 32'(OPAQUE), 32'h1);
      chk("stream_bank", 32'(BANK), 32'h1);
      #2 nRST = 1'b0;
      #1;
      chk("arst_pa", 32'(PA_OUT), 32'h0);
      chk("arst_opq", 32'(OPAQUE), 32'h0);
      chk("arst_bank", 32'(BANK), 32'h0);
      #2 nRST = 1'b1;
      RD_EN = 1'b0;
      step();
      step();
      chk("post_rst_pa", 32'(PA_OUT), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
